// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among NREQ writeback requesters.
// Runs a zero-fill clear pass after reset or on init_start.
//
// state | meaning
// CLEAR | writing zero to x1..x(NREGS-1), one register per cycle; requests held off
// RUN   | round-robin arbitration, one accepted write per cycle
module regfile_wb_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_rd,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     init_start,
    output logic                     init_busy,
    output logic                     rf_RegWrite,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_writeData,
    output logic [1:0]               grant_id
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [1:0]        rr_ptr;

    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    logic [1:0]        gnt_off;
    logic [2:0]        gnt_sum;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic [1:0]        rr_next;
    logic              accept_ok;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    assign init_busy = (state == CLEAR);
    assign accept_ok = (state == RUN) && !init_start;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr; the lowest set bit wins.
    assign valid_dbl = {req_valid, req_valid};

    always_comb begin
        valid_rot = valid_dbl[NREQ-1:0];
        gnt_any   = 1'b0;
        gnt_off   = 2'd0;
        gnt_sum   = 3'd0;
        gnt_idx   = 2'd0;
        valid_rot = NREQ'(valid_dbl >> rr_ptr);
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                gnt_any = 1'b1;
                gnt_off = 2'(k);
            end
        end
        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        if (gnt_sum >= 3'(NREQ)) begin
            gnt_sum = gnt_sum - 3'(NREQ);
        end
        gnt_idx = gnt_sum[1:0];
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == 2'(k)) begin
                sel_rd   = req_rd[k*ADDR_W +: ADDR_W];
                sel_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = accept_ok && gnt_any && (gnt_idx == 2'(k));
        end
    end

    assign rr_next = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            clr_ptr      <= ADDR_W'(1);
            rr_ptr       <= 2'd0;
            rf_RegWrite  <= 1'b0;
            rf_rd        <= '0;
            rf_writeData <= '0;
            grant_id     <= 2'd0;
        end else begin
            case (state)
                CLEAR: begin
                    rf_RegWrite  <= 1'b1;
                    rf_rd        <= clr_ptr;
                    rf_writeData <= '0;
                    clr_ptr      <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(NREGS - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (init_start) begin
                        state       <= CLEAR;
                        clr_ptr     <= ADDR_W'(1);
                        rf_RegWrite <= 1'b0;
                    end else if (gnt_any) begin
                        // x0 writes are accepted but never reach the register file.
                        rf_RegWrite  <= (sel_rd != '0);
                        rf_rd        <= sel_rd;
                        rf_writeData <= sel_data;
                        grant_id     <= gnt_idx;
                        rr_ptr       <= rr_next;
                    end else begin
                        rf_RegWrite <= 1'b0;
                    end
                end
                default: begin
                    state       <= CLEAR;
                    clr_ptr     <= ADDR_W'(1);
                    rf_RegWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear pass, round-robin grants, x0 drop,
// init_start priority and reset mid-clear.
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 2;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_rd;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   init_start;
    logic                   init_busy;
    logic                   rf_RegWrite;
    logic [ADDR_W-1:0]      rf_rd;
    logic [DATA_W-1:0]      rf_writeData;
    logic [1:0]             grant_id;

    logic [DATA_W-1:0]      rf_model [NREGS];

    int tests_run;
    int tests_failed;

    regfile_wb_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_rd(req_rd),
        .req_data(req_data),
        .req_ready(req_ready),
        .init_start(init_start),
        .init_busy(init_busy),
        .rf_RegWrite(rf_RegWrite),
        .rf_rd(rf_rd),
        .rf_writeData(rf_writeData),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for registerFile so a read-back can be checked.
    always @(posedge clk) begin
        if (rf_RegWrite && rf_rd != '0) begin
            rf_model[rf_rd] <= rf_writeData;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < NREGS; i++) rf_model[i] = '1;
        reset      = 1'b1;
        req_valid  = '0;
        req_rd     = '0;
        req_data   = '0;
        init_start = 1'b0;
        tick();
        tick();

        check("rst_regwrite", 64'(rf_RegWrite), 64'd0);
        check("rst_rd", 64'(rf_rd), 64'd0);
        check("rst_wdata", rf_writeData, 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(init_busy), 64'd1);

        // Clear pass after reset
        reset = 1'b0;
        for (int k = 1; k <= NREGS - 1; k++) begin
            check("clr_busy", 64'(init_busy), 64'd1);
            tick();
            check("clr_regwrite", 64'(rf_RegWrite), 64'd1);
            check("clr_rd", 64'(rf_rd), 64'(k));
            check("clr_wdata", rf_writeData, 64'd0);
        end
        check("clr_done_busy", 64'(init_busy), 64'd0);
        tick();
        check("run_idle_regwrite", 64'(rf_RegWrite), 64'd0);
        check("model_x9_zero", rf_model[9], 64'd0);

        // Single request from requester 0
        req_rd[0 +: ADDR_W]   = 5'd5;
        req_data[0 +: DATA_W] = 64'd99;
        req_valid             = 2'b01;
        #1;
        check("r0_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        check("r0_regwrite", 64'(rf_RegWrite), 64'd1);
        check("r0_rd", 64'(rf_rd), 64'd5);
        check("r0_wdata", rf_writeData, 64'd99);
        check("r0_grant", 64'(grant_id), 64'd0);
        tick();
        check("idle_regwrite", 64'(rf_RegWrite), 64'd0);
        check("idle_rd_hold", 64'(rf_rd), 64'd5);
        check("idle_wdata_hold", rf_writeData, 64'd99);
        check("model_x5", rf_model[5], 64'd99);

        // x0 request from requester 1: accepted, not written
        req_rd[ADDR_W +: ADDR_W]   = 5'd0;
        req_data[DATA_W +: DATA_W] = 64'd123;
        req_valid                  = 2'b10;
        #1;
        check("x0_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        check("x0_regwrite", 64'(rf_RegWrite), 64'd0);
        tick();
        tick();

        // Both valid, rr_ptr back at 0: grants alternate starting with 0
        req_rd[0 +: ADDR_W]        = 5'd3;
        req_data[0 +: DATA_W]      = 64'h30;
        req_rd[ADDR_W +: ADDR_W]   = 5'd7;
        req_data[DATA_W +: DATA_W] = 64'h70;
        req_valid                  = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("alt_ready", 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            check("alt_regwrite", 64'(rf_RegWrite), 64'd1);
            check("alt_rd", 64'(rf_rd), (c % 2 == 0) ? 64'd3 : 64'd7);
            check("alt_wdata", rf_writeData, (c % 2 == 0) ? 64'h30 : 64'h70);
            check("alt_grant", 64'(grant_id), 64'(c % 2));
        end
        req_valid = 2'b00;
        tick();

        // init_start beats a pending request; request waits out the clear pass
        req_rd[0 +: ADDR_W]   = 5'd9;
        req_data[0 +: DATA_W] = 64'h55;
        req_valid             = 2'b01;
        init_start            = 1'b1;
        #1;
        check("init_ready", 64'(req_ready), 64'h0);
        tick();
        init_start = 1'b0;
        check("init_busy", 64'(init_busy), 64'd1);
        check("init_regwrite", 64'(rf_RegWrite), 64'd0);
        for (int k = 1; k <= NREGS - 1; k++) begin
            init_start = (k == 5);
            #1;
            check("clr2_ready", 64'(req_ready), 64'h0);
            tick();
            check("clr2_rd", 64'(rf_rd), 64'(k));
        end
        init_start = 1'b0;
        #1;
        check("held_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        check("held_regwrite", 64'(rf_RegWrite), 64'd1);
        check("held_rd", 64'(rf_rd), 64'd9);
        check("held_wdata", rf_writeData, 64'h55);
        check("held_grant", 64'(grant_id), 64'd0);
        tick();

        // Reset in the middle of a clear pass
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        check("mid_rd", 64'(rf_rd), 64'd10);
        reset = 1'b1;
        tick();
        check("mid_rst_regwrite", 64'(rf_RegWrite), 64'd0);
        reset = 1'b0;
        tick();
        check("restart_rd", 64'(rf_rd), 64'd1);
        check("restart_regwrite", 64'(rf_RegWrite), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
